// File: rtl/segdac_multi_driver.sv
// Front-end for NUM_CH segmented current-steering DACs: bias power-up sequencing,
// pixel/ramp source selection and a 2-stage binary-to-thermometer segment encoder.
//
// state | meaning
// OFF   | powered down, all biases off
// B1    | bias1 on, settling for BIAS_DLY cycles
// B2    | bias1..2 on, settling for BIAS_DLY cycles
// B3    | bias1..3 on, settling for BIAS_DLY cycles
// RUN   | fully biased, switch outputs live
module segdac_multi_driver #(
  parameter int NUM_CH    = 3,
  parameter int SEGS      = 4,
  parameter int SEG_W     = 2,
  parameter int BIAS_DLY  = 4,
  parameter int RAMP_STEP = 64
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       en,
  input  logic [1:0]                                 mode,
  input  logic [NUM_CH-1:0]                          ch_mask,
  input  logic                                       pix_valid,
  input  logic [NUM_CH*SEGS*SEG_W-1:0]               pix_data,
  output logic [NUM_CH*SEGS*((1<<SEG_W)-1)-1:0]      dac_sw,
  output logic [NUM_CH*3-1:0]                        bias,
  output logic                                       ready,
  output logic                                       out_valid
);

  localparam int CW    = SEGS * SEG_W;
  localparam int TW    = (1 << SEG_W) - 1;
  localparam int DW    = NUM_CH * CW;
  localparam int SW    = NUM_CH * SEGS * TW;
  localparam int CNT_W = $clog2(BIAS_DLY + 1);

  localparam logic [CNT_W-1:0] DLY_M1 = CNT_W'(BIAS_DLY - 1);

  localparam logic [2:0] S_OFF = 3'd0;
  localparam logic [2:0] S_B1  = 3'd1;
  localparam logic [2:0] S_B2  = 3'd2;
  localparam logic [2:0] S_B3  = 3'd3;
  localparam logic [2:0] S_RUN = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CW-1:0]    ramp_q, ramp_d;
  logic [DW-1:0]    d1_q, d1_d;
  logic             v1_q, v1_d;
  logic [SW-1:0]    sw_q, sw_d;
  logic             v2_q, v2_d;
  logic [SW-1:0]    enc;
  logic [2:0]       bias_stage;
  logic             run;

  // Stage timer is a down-counter; leaving a bias stage on terminal count 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!en) begin
      state_d = S_OFF;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_OFF: begin
          state_d = S_B1;
          cnt_d   = DLY_M1;
        end
        S_B1, S_B2, S_B3: begin
          if (cnt_q == '0) begin
            state_d = (state_q == S_B1) ? S_B2 : (state_q == S_B2) ? S_B3 : S_RUN;
            cnt_d   = (state_q == S_B3) ? '0 : DLY_M1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_RUN: state_d = S_RUN;
        default: begin
          state_d = S_OFF;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    case (state_q)
      S_B1:         bias_stage = 3'b001;
      S_B2:         bias_stage = 3'b011;
      S_B3, S_RUN:  bias_stage = 3'b111;
      default:      bias_stage = 3'b000;
    endcase
    for (int c = 0; c < NUM_CH; c++) begin
      bias[c*3 +: 3] = ch_mask[c] ? bias_stage : 3'b000;
    end
  end

  assign run   = (state_q == S_RUN);
  assign ready = run;

  // Stage 1: source select. Hold mode keeps the register but emits no valid.
  always_comb begin
    d1_d   = d1_q;
    v1_d   = 1'b0;
    ramp_d = ramp_q;
    if (pix_valid) begin
      case (mode)
        2'd0: begin
          d1_d = pix_data;
          v1_d = 1'b1;
        end
        2'd1: begin
          for (int c = 0; c < NUM_CH; c++) begin
            d1_d[c*CW +: CW] = ramp_q + CW'(c * RAMP_STEP);
          end
          v1_d   = 1'b1;
          ramp_d = ramp_q + 1'b1;
        end
        2'd3: begin
          d1_d = '0;
          v1_d = 1'b1;
        end
        default: v1_d = 1'b0;
      endcase
    end
  end

  always_comb begin
    enc = '0;
    for (int g = 0; g < NUM_CH * SEGS; g++) begin
      for (int j = 0; j < TW; j++) begin
        enc[g*TW + j] = (j < int'(d1_q[g*SEG_W +: SEG_W]));
      end
    end
  end

  // Stage 2 is cleared outside RUN so pre-RUN data can never surface later.
  always_comb begin
    v2_d = v1_q;
    if (state_d != S_RUN) begin
      sw_d = '0;
    end else if (v1_q) begin
      sw_d = enc;
    end else begin
      sw_d = sw_q;
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      dac_sw[c*SEGS*TW +: SEGS*TW] = (run && ch_mask[c]) ? sw_q[c*SEGS*TW +: SEGS*TW] : '0;
    end
  end

  assign out_valid = v2_q && run;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      ramp_q  <= '0;
      d1_q    <= '0;
      v1_q    <= 1'b0;
      sw_q    <= '0;
      v2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ramp_q  <= ramp_d;
      d1_q    <= d1_d;
      v1_q    <= v1_d;
      sw_q    <= sw_d;
      v2_q    <= v2_d;
    end
  end

endmodule

// File: tb/tb_segdac_multi_driver.sv
// Randomized scoreboard bench for segdac_multi_driver with a cycle-count reference model.
module tb_segdac_multi_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [1:0]  mode;
  logic [2:0]  ch_mask;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic [35:0] dac_sw;
  logic [8:0]  bias;
  logic        ready;
  logic        out_valid;

  segdac_multi_driver dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .ch_mask(ch_mask),
    .pix_valid(pix_valid), .pix_data(pix_data), .dac_sw(dac_sw), .bias(bias),
    .ready(ready), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [35:0] sw;
  } item_t;

  item_t       sb_q[$];
  int          cyc = 0;
  int          streak = 0;
  int          ramp_m = 0;
  int          n_checks = 0;
  int          n_err = 0;
  logic [35:0] last_m = '0;

  function automatic logic [11:0] therm8(input int code);
    logic [11:0] r;
    int v;
    r = '0;
    for (int s = 0; s < 4; s++) begin
      v = (code >> (2 * s)) % 4;
      for (int j = 0; j < 3; j++) r[s*3 + j] = (j < v);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: sequencer state follows from how many consecutive edges saw en=1.
  always @(posedge clk) begin
    item_t it;
    int code;
    cyc++;
    if (!rst_n) begin
      streak = 0;
      ramp_m = 0;
      sb_q.delete();
    end else begin
      streak = en ? streak + 1 : 0;
      if (pix_valid && mode != 2'd2) begin
        it.due = cyc + 1;
        it.sw  = '0;
        for (int c = 0; c < 3; c++) begin
          case (mode)
            2'd0:    code = int'(pix_data[c*8 +: 8]);
            2'd1:    code = (ramp_m + 64 * c) % 256;
            default: code = 0;
          endcase
          it.sw[c*12 +: 12] = therm8(code);
        end
        if (mode == 2'd1) ramp_m = (ramp_m + 1) % 256;
        sb_q.push_back(it);
      end
    end
  end

  // Monitor: sample 1 time unit after the edge, pop on out_valid.
  always @(posedge clk) begin
    logic        run;
    logic        exp_valid;
    logic [2:0]  stage;
    logic [8:0]  exp_bias;
    logic [35:0] exp_sw;
    item_t       it;
    #1;
    run = (streak >= 13);
    while (sb_q.size() > 0 && (sb_q[0].due < cyc || (sb_q[0].due == cyc && !run)))
      void'(sb_q.pop_front());
    if (!run) last_m = '0;
    stage = (streak == 0) ? 3'b000 : (streak <= 4) ? 3'b001 : (streak <= 8) ? 3'b011 : 3'b111;
    for (int c = 0; c < 3; c++) exp_bias[c*3 +: 3] = ch_mask[c] ? stage : 3'b000;
    check("bias", 64'(bias), 64'(exp_bias));
    check("ready", 64'(ready), 64'(run));
    exp_valid = (sb_q.size() > 0 && sb_q[0].due == cyc);
    check("out_valid", 64'(out_valid), 64'(exp_valid));
    if (exp_valid) begin
      it = sb_q.pop_front();
      last_m = it.sw;
    end
    for (int c = 0; c < 3; c++) exp_sw[c*12 +: 12] = (run && ch_mask[c]) ? last_m[c*12 +: 12] : 12'h000;
    check("dac_sw", 64'(dac_sw), 64'(exp_sw));
  end

  task automatic rand_pix();
    pix_data  = 24'($urandom);
    pix_valid = 1'($urandom);
    mode      = 2'($urandom);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; ch_mask = 3'b111;
    rand_pix();
    @(negedge clk);
    en = 1'($urandom); ch_mask = 3'($urandom); rand_pix();
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1; ch_mask = 3'b111;
    repeat (14) begin rand_pix(); @(negedge clk); end

    // Directed encode in RUN
    mode = 2'd0; pix_valid = 1'b1; pix_data = {8'h00, 8'hFF, 8'hE4};
    @(negedge clk);
    pix_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Masking and hold
    ch_mask = 3'b101;
    repeat (2) @(negedge clk);
    mode = 2'd2; pix_valid = 1'b1; pix_data = 24'($urandom);
    repeat (3) @(negedge clk);
    pix_valid = 1'b0; ch_mask = 3'b111;
    @(negedge clk);

    repeat (150) begin
      rand_pix();
      if ($urandom_range(0, 7) == 0) ch_mask = 3'($urandom);
      @(negedge clk);
    end
    ch_mask = 3'b111;

    // en drop during back-to-back pixels, then full re-sequence
    mode = 2'd0; pix_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pix_data = 24'($urandom);
      en = (i != 3);
      @(negedge clk);
    end
    repeat (16) begin pix_data = 24'($urandom); @(negedge clk); end

    // Ramp from reset: 257 back-to-back strobes once in RUN
    rst_n = 1'b0; pix_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; mode = 2'd0;
    repeat (13) @(negedge clk);
    mode = 2'd1; pix_valid = 1'b1;
    repeat (257) @(negedge clk);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);

    // Random soak with occasional en drops and resets
    repeat (400) begin
      rand_pix();
      en    = ($urandom_range(0, 31) != 0);
      rst_n = ($urandom_range(0, 63) != 0);
      if ($urandom_range(0, 15) == 0) ch_mask = 3'($urandom);
      @(negedge clk);
    end
    rst_n = 1'b1; en = 1'b1; pix_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
